// File: rtl/mux_arb_pkg.sv
// Shared definitions for the two-requester mux arbiter: state encoding,
// counter widths and default parameters.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_G1   = 2'b01,
    ARB_G2   = 2'b10
  } arb_state_t;

  localparam int STATS_W      = 16;
  localparam int DEFAULT_HOLD = 8;
  localparam int DEFAULT_SIZE = 4;

  // Enough bits to represent 0..hold, so HOLD-1 always fits.
  function automatic int hold_cnt_width(input int hold);
    return $clog2(hold + 1);
  endfunction

endpackage

// File: rtl/mux_arbiter_if.sv
// Request/data/grant bundle between the requesters and the mux arbiter.
interface mux_arbiter_if
  import mux_arb_pkg::*;
#(
  parameter int SIZE = DEFAULT_SIZE
);

  logic            req1_;
  logic            req2_;
  logic [SIZE-1:0] inp1_;
  logic [SIZE-1:0] inp2_;
  logic            gnt1_;
  logic            gnt2_;
  logic [SIZE-1:0] out_data_;
  logic            out_valid_;

  modport master (
    output req1_, req2_, inp1_, inp2_,
    input  gnt1_, gnt2_, out_data_, out_valid_
  );

  modport slave (
    input  req1_, req2_, inp1_, inp2_,
    output gnt1_, gnt2_, out_data_, out_valid_
  );

endinterface

// File: rtl/arb_hold_counter.sv
// Saturating grant-hold counter; terminal flags the last cycle a grant may
// be held while the other requester is waiting.
module arb_hold_counter
  import mux_arb_pkg::*;
#(
  parameter int HOLD = DEFAULT_HOLD
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int CW = hold_cnt_width(HOLD);
  localparam logic [CW-1:0] LAST = CW'(HOLD - 1);

  logic [CW-1:0] count_q;

  assign terminal = (count_q == LAST);

  // Clear wins over enable; once terminal the count parks there.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && !terminal) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin, hold-bounded arbiter for a two-input mux with a registered
// valid-qualified output. Optional grant-entry counters: MUX_ARB_STATS_EN.
module mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int SIZE = DEFAULT_SIZE,
  parameter int HOLD = DEFAULT_HOLD
) (
  input  logic                clk,
  input  logic                rst,
`ifdef MUX_ARB_STATS_EN
  output logic [STATS_W-1:0]  gcnt1_,
  output logic [STATS_W-1:0]  gcnt2_,
`endif
  mux_arbiter_if.slave        bus
);

  arb_state_t state_q;
  arb_state_t cur_state;
  arb_state_t state_d;
  logic [1:0] last_q;
  logic       hold_clr;
  logic       hold_en;
  logic       hold_term;
  logic       enter1;
  logic       enter2;
  logic       gnt1;
  logic       gnt2;
  logic [SIZE-1:0] data_q;
  logic            valid_q;

  arb_hold_counter #(
    .HOLD (HOLD)
  ) u_hold (
    .clk      (clk),
    .rst      (rst),
    .clear    (hold_clr),
    .enable   (hold_en),
    .terminal (hold_term)
  );

  // The unused encoding 2'b11 behaves exactly like IDLE.
  always_comb begin
    case (state_q)
      ARB_G1:  cur_state = ARB_G1;
      ARB_G2:  cur_state = ARB_G2;
      default: cur_state = ARB_IDLE;
    endcase
  end

  always_comb begin
    state_d  = cur_state;
    hold_clr = 1'b1;
    hold_en  = 1'b0;
    case (cur_state)
      ARB_G1: begin
        if (!bus.req1_) begin
          state_d = bus.req2_ ? ARB_G2 : ARB_IDLE;
        end else if (hold_term && bus.req2_) begin
          state_d = ARB_G2;
        end else begin
          hold_clr = 1'b0;
          hold_en  = 1'b1;
        end
      end
      ARB_G2: begin
        if (!bus.req2_) begin
          state_d = bus.req1_ ? ARB_G1 : ARB_IDLE;
        end else if (hold_term && bus.req1_) begin
          state_d = ARB_G1;
        end else begin
          hold_clr = 1'b0;
          hold_en  = 1'b1;
        end
      end
      default: begin
        if (bus.req1_ && bus.req2_) begin
          state_d = (last_q == 2'd1) ? ARB_G2 : ARB_G1;
        end else if (bus.req1_) begin
          state_d = ARB_G1;
        end else if (bus.req2_) begin
          state_d = ARB_G2;
        end
      end
    endcase
  end

  always_comb begin
    enter1 = (state_d == ARB_G1) && (cur_state != ARB_G1);
    enter2 = (state_d == ARB_G2) && (cur_state != ARB_G2);
    gnt1   = (cur_state == ARB_G1);
    gnt2   = (cur_state == ARB_G2);
  end

  // last_q holds the requester id (1 or 2); reset value 2 lets req1_ win
  // the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      last_q  <= 2'd2;
    end else begin
      state_q <= state_d;
      if (enter1) begin
        last_q <= 2'd1;
      end else if (enter2) begin
        last_q <= 2'd2;
      end
    end
  end

  // Word of the requester granted this cycle; holds when nobody is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= gnt1 || gnt2;
      if (gnt1) begin
        data_q <= bus.inp1_;
      end else if (gnt2) begin
        data_q <= bus.inp2_;
      end
    end
  end

  always_comb begin
    bus.gnt1_      = gnt1;
    bus.gnt2_      = gnt2;
    bus.out_data_  = data_q;
    bus.out_valid_ = valid_q;
  end

`ifdef MUX_ARB_STATS_EN
  logic [STATS_W-1:0] gcnt1_q;
  logic [STATS_W-1:0] gcnt2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      gcnt1_q <= '0;
      gcnt2_q <= '0;
    end else begin
      if (enter1) begin
        gcnt1_q <= gcnt1_q + 1'b1;
      end
      if (enter2) begin
        gcnt2_q <= gcnt2_q + 1'b1;
      end
    end
  end

  assign gcnt1_ = gcnt1_q;
  assign gcnt2_ = gcnt2_q;
`endif

endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

Sequential arbiter that shares the SIZE-bit two-input mux datapath between two requesters. Each requester presents a request and a data word. The block grants one requester at a time, round-robin with a bounded hold time. Grant outputs drive the mux select switches directly, and the block registers the selected word onto a valid-qualified output toward the LED/display stage.

## Interface
- SIZE, 4, data width of each requester word and of the output.
- HOLD, 8, maximum consecutive grant cycles while the other requester waits; legal range 1..255.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- req1_  in  1  requester 1 request; held high while it wants the mux.
- req2_  in  1  requester 2 request.
- inp1_  in  SIZE  requester 1 data word.
- inp2_  in  SIZE  requester 2 data word.
- gnt1_  out  1  grant to requester 1; drives mux select 1.
- gnt2_  out  1  grant to requester 2; drives mux select 2.
- out_data_  out  SIZE  registered word of the requester granted in the previous cycle.
- out_valid_  out  1  out_data_ qualifier.
- gcnt1_, gcnt2_  out  16 each  grant-entry counters (only with MUX_ARB_STATS_EN).

## Operation
- **Reset state.** State IDLE, hold counter 0, last-granted = 2, gnt1_/gnt2_ = 0, out_data_ = 0, out_valid_ = 0, gcnt1_/gcnt2_ = 0.
- **States.** Three states: IDLE, G1, G2. gnt1_ = (state==G1) and gnt2_ = (state==G2), decoded from registered state. The two grants are never high together.
- **IDLE.**
  - Only one request high: go to that requester's G state.
  - Both high: grant the requester that was not last granted. After reset, req1_ wins the first tie.
  - Neither high: stay in IDLE.
- **Gk (k = 1 or 2; o = the other requester).** The hold counter increments each cycle and saturates at HOLD-1. Transitions are evaluated in this order:
  - reqk_ low and reqo_ high: go directly to Go with no idle cycle. The counter clears.
  - reqk_ low and reqo_ low: go to IDLE. The counter clears.
  - counter == HOLD-1 and reqo_ high: go to Go (forced handoff). The counter clears.
  - Otherwise: stay in Gk. When reqo_ is low, the grant continues indefinitely and the counter stays saturated.
- **Last-granted.** Updated on every entry into G1 or G2.
- **Output path.** On each edge, out_valid_ <= (state is G1 or G2), and out_data_ <= inpk_ of the currently granted requester. When no requester is granted, out_data_ holds its previous value and out_valid_ = 0.
- **HOLD = 1.** With both requests high, the grant alternates every cycle.
- **Width rules.** The hold counter is ceil(log2(HOLD+1)) bits. Data is passed through unmodified; no arithmetic is performed on data.
- **Reset mid-operation.** rst overrides all transitions. At the next edge every register returns to its reset value regardless of state. A grant in progress is dropped without a final out_valid_.

## Timing
- **Request to grant.** A request sampled high at edge N raises gnt after edge N, so the grant is visible in cycle N.
- **Data.** The granted word is sampled at edge N+1, and out_valid_/out_data_ are high and valid after edge N+1. Request-to-output latency is 2 edges.
- **Handoff.** At a grant handoff, gntk_ falls and gnto_ rises after the same edge. out_data_ switches source one cycle later, with no invalid gap.
- **Release.** After a request drops at edge M, the grant is gone after edge M. out_valid_ falls after edge M+1.
- **Requester obligations.** Requesters keep inpk_ stable while gntk_ is high.

## Configuration
- **MUX_ARB_STATS_EN defined.** gcnt1_/gcnt2_ exist. Each increments by 1 on every entry into its G state, including forced handoffs, and wraps from 16'hFFFF to 0. Both reset to 0 on rst.
- **MUX_ARB_STATS_EN undefined.** The ports and counters are absent; all other behaviour is identical.

## Structure
- **Shared package mux_arb_pkg** holds:
  - the state encoding: IDLE = 2'b00, G1 = 2'b01, G2 = 2'b10, with 2'b11 illegal and decoded as IDLE;
  - the stats counter width constant (16);
  - the default HOLD.
- **Sub-module arb_hold_counter** is a saturating counter with clear, enable and a terminal flag. Its width derives from HOLD.

## Test plan
- Reset, then req1_=1 with inp1_=4'hF: gnt1_ high after the first edge. out_data_=4'hF and out_valid_=1 after the second edge. gnt2_ stays 0.
- Both requests high from reset, inp1_=4'hF, inp2_=4'h7, HOLD=8: G1 for 8 cycles, then G2 for 8 cycles, alternating. out_data_ follows one cycle behind. gnt1_ and gnt2_ are never high together.
- req1_ alone held for 20 cycles: gnt1_ stays high for all 20 cycles with no handoff. req1_ drops: IDLE after the next edge, out_valid_ = 0 one cycle later.
- In G1 at counter 3, req1_ drops and req2_ is high in the same cycle: G2 after that edge with no idle cycle. out_valid_ stays 1 across the handoff.
- rst pulsed for 1 cycle while in G2 at counter 5: all outputs are at reset values after the edge. With both requests still high, G1 is granted next (last-granted reset to 2).
- With MUX_ARB_STATS_EN, 3 full round-robin rotations: gcnt1_ = 3 and gcnt2_ = 3. Without the macro, the bench compiles without the stats ports.
